// File: rtl/dmem_pkg.sv
// Shared types, widths and address checking for the data-memory responder.
// Imported by dmem_responder and dmem_array.
package dmem_pkg;

    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Flags a byte address that is not word aligned or lies beyond the array.
    function automatic logic dmem_addr_err(input logic [WORD_W-1:0] addr, input int depth_log2);
        logic [WORD_W-1:0] high_bits;
        high_bits = addr >> (depth_log2 + OFFSET_W);
        return (addr[OFFSET_W-1:0] != '0) || (high_bits != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with synchronous write and combinational read.
// Contents are not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // NOTE: storage arrays carry no reset; resetting every word would force
    // flops instead of RAM and is not needed because contents start undefined.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, programmable wait
// states, commit to the word array, then a held valid/ready response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 7,
    parameter int LATENCY    = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [WORD_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [WORD_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);

    localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    dmem_state_t       state;
    dmem_state_t       state_next;
    logic [3:0]        count;
    logic              lat_write;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              commit;
    logic              c_write;
    logic [WORD_W-1:0] c_addr;
    logic [WORD_W-1:0] c_wdata;
    logic              c_err;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign accept       = req_valid_i & req_ready_o;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY == 0) begin
                        commit     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A zero-latency commit happens at the acceptance edge, so it must use the
    // live request rather than the latched copy.
    assign c_write = (state == IDLE) ? req_write_i : lat_write;
    assign c_addr  = (state == IDLE) ? req_addr_i  : lat_addr;
    assign c_wdata = (state == IDLE) ? req_wdata_i : lat_wdata;
    assign c_err   = dmem_addr_err(c_addr, DEPTH_LOG2);
    assign arr_we  = commit & c_write & ~c_err;

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk_i (clk_i),
        .we    (arr_we),
        .idx   (c_addr[DEPTH_LOG2+OFFSET_W-1:OFFSET_W]),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write_i;
                lat_addr  <= req_addr_i;
                lat_wdata <= req_wdata_i;
                count     <= CNT_LOAD;
            end else if ((state == WAIT) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
            if (commit) begin
                rdata_q <= (c_write || c_err) ? '0 : arr_rdata;
                err_q   <= c_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a vector
// table and hand sequences, plus a LATENCY=0 instance for the zero-wait path.
module tb_dmem_responder;

    localparam int LAT_A = 2;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        req_valid_b, req_ready_b, req_write_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH_LOG2(7), .LATENCY(LAT_A)) dut_a (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err)
    );

    dmem_responder #(.DEPTH_LOG2(7), .LATENCY(0)) dut_b (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_b),
        .req_ready_o  (req_ready_b),
        .req_write_i  (req_write_b),
        .req_addr_i   (req_addr_b),
        .req_wdata_i  (req_wdata_b),
        .resp_valid_o (resp_valid_b),
        .resp_ready_i (resp_ready_b),
        .resp_rdata_o (resp_rdata_b),
        .resp_err_o   (resp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on dut_a, called #1 after a rising edge in IDLE.
    task automatic txn(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ee);
        int n;
        check({name, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, LAT_A);
        check({name, " rdata"}, resp_rdata, er);
        check({name, " err"}, {31'd0, resp_err}, {31'd0, ee});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({name, " valid drop"}, {31'd0, resp_valid}, 32'd0);
        check({name, " ready back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int acc;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_01FC, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_01FC, 32'h0000_0000, 32'h1122_3344, 1'b0};
        vecs[8] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[9] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; resp_ready_b = 1'b0;
        tick();
        tick();
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", {31'd0, resp_err}, 32'd0);
        check("reset b resp_valid", {31'd0, resp_valid_b}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: a store to the same word is held on the request port
        // through WAIT and RESP and must be ignored.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = '0;
        tick();
        req_write = 1'b1; req_wdata = 32'h5555_5555;
        acc = 0;
        while (!resp_valid && acc < 40) begin
            check("bp ready low in wait", {31'd0, req_ready}, 32'd0);
            tick();
            acc++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp valid c%0d", i), {31'd0, resp_valid}, 32'd1);
            check($sformatf("bp rdata c%0d", i), resp_rdata, 32'hDEAD_BEEF);
            check($sformatf("bp ready c%0d", i), {31'd0, req_ready}, 32'd0);
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp ready after hs", {31'd0, req_ready}, 32'd1);
        txn("bp reload", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset one cycle after accepting a store, before its commit edge.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst mid req_ready", {31'd0, req_ready}, 32'd1);
        check("rst mid resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst mid resp_rdata", resp_rdata, 32'd0);
        check("rst mid resp_err", {31'd0, resp_err}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        txn("rst aborted store", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Zero-latency instance: response in the cycle right after acceptance.
        req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 32'h8; req_wdata_b = 32'hA5A5_A5A5;
        tick();
        check("b store valid", {31'd0, resp_valid_b}, 32'd1);
        check("b store err", {31'd0, resp_err_b}, 32'd0);
        check("b store ready", {31'd0, req_ready_b}, 32'd0);
        req_write_b = 1'b0;
        resp_ready_b = 1'b1;
        tick();
        check("b hs valid", {31'd0, resp_valid_b}, 32'd0);
        check("b hs ready", {31'd0, req_ready_b}, 32'd1);
        tick();
        check("b load valid", {31'd0, resp_valid_b}, 32'd1);
        check("b load rdata", resp_rdata_b, 32'hA5A5_A5A5);
        tick();
        check("b back idle", {31'd0, req_ready_b}, 32'd1);

        // Continuous loads with response always taken: one accept per 2 cycles.
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready_b) acc++;
            tick();
        end
        req_valid_b = 1'b0;
        check("b throughput", acc, 32'd5);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
